// File: rtl/dance_pkg.sv
// rtl/dance_pkg.sv - shared LED-dance constants, pattern encoding and monitor states
package dance_pkg;
    localparam int N_LEDS = 18;
    localparam int POS_W  = 5;

    typedef enum logic [1:0] {
        UNKNOWN = 2'd0,
        UP      = 2'd1,
        DOWN    = 2'd2,
        BOUNCE  = 2'd3
    } pattern_t;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;
endpackage

// File: rtl/led_onehot_enc.sv
// rtl/led_onehot_enc.sv - classifies an LED frame as single/blank/multi and encodes the lit index
module led_onehot_enc
    import dance_pkg::*;
(
    input  logic [N_LEDS-1:0] led_i,
    output logic [POS_W-1:0]  p_o,
    output logic              is_single_o,
    output logic              is_blank_o,
    output logic              is_multi_o
);
    always_comb begin
        p_o = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            if (led_i[i]) p_o = POS_W'(i);
        end
    end

    // clearing the lowest set bit leaves zero only for a one-hot vector
    assign is_blank_o  = (led_i == '0);
    assign is_single_o = !is_blank_o && ((led_i & (led_i - N_LEDS'(1))) == '0);
    assign is_multi_o  = !is_blank_o && !is_single_o;
endmodule

// File: rtl/dance_monitor.sv
// rtl/dance_monitor.sv - tracks a running-light LED sequence, locks onto it and flags breaks
module dance_monitor
    import dance_pkg::*;
#(
    parameter int LOCK_N   = 4,
    parameter int HOLD_MAX = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              sample_i,
    input  logic [N_LEDS-1:0] led_i,
    output logic [POS_W-1:0]  position_o,
    output logic [1:0]        pattern_o,
    output logic              locked_o,
    output logic              error_o,
    output logic [7:0]        err_count_o
);
    localparam logic [POS_W-1:0] LAST       = POS_W'(N_LEDS - 1);
    localparam logic [7:0]       LOCK_N_W   = 8'(LOCK_N);
    localparam logic [7:0]       HOLD_MAX_W = 8'(HOLD_MAX);

    logic [POS_W-1:0] p;
    logic             single, blank, multi;

    led_onehot_enc u_enc (
        .led_i       (led_i),
        .p_o         (p),
        .is_single_o (single),
        .is_blank_o  (blank),
        .is_multi_o  (multi)
    );

    state_t           state_q;
    pattern_t         pattern_q, dir_q, dir_d;
    logic [POS_W-1:0] position_q, prev_q;
    logic [7:0]       stp_q, hld_q, hld_d, err_count_q;
    logic             locked_q, error_q, wrap_q;

    logic p_up, p_dn, first, hold, step_ok, rev, blank_ok, consistent;

    always_comb begin
        p_up     = (prev_q != LAST) && (p == prev_q + 5'd1);
        p_dn     = (prev_q != 5'd0) && (p == prev_q - 5'd1);
        first    = (state_q == TRACK) && (stp_q == 8'd0);
        hold     = single && (p == prev_q) && !wrap_q;
        hld_d    = hld_q + 8'd1;
        step_ok  = 1'b0;
        rev      = 1'b0;
        dir_d    = dir_q;
        if (single && !hold) begin
            if (wrap_q) begin
                step_ok = (p == 5'd0);
            end else if (first) begin
                if (p_up) begin
                    step_ok = 1'b1;
                    dir_d   = UP;
                end else if (p_dn || (prev_q == 5'd0 && p == LAST)) begin
                    step_ok = 1'b1;
                    dir_d   = DOWN;
                end
            end else if (dir_q == UP) begin
                if (p_up) begin
                    step_ok = 1'b1;
                end else if (p_dn && prev_q >= LAST - 5'd1) begin
                    step_ok = 1'b1;
                    rev     = 1'b1;
                    dir_d   = DOWN;
                end
            end else begin
                if (p_dn || (prev_q == 5'd0 && p == LAST)) begin
                    step_ok = 1'b1;
                end else if (p_up && prev_q <= 5'd1) begin
                    step_ok = 1'b1;
                    rev     = 1'b1;
                    dir_d   = UP;
                end
            end
        end
        // the UP wrap passes through one dark frame between the last and first LED
        blank_ok   = blank && !first && !wrap_q && (prev_q == LAST) && (dir_q == UP);
        consistent = step_ok || blank_ok || (hold && hld_d <= HOLD_MAX_W);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= HUNT;
            position_q  <= '0;
            pattern_q   <= UNKNOWN;
            locked_q    <= 1'b0;
            error_q     <= 1'b0;
            err_count_q <= '0;
            stp_q       <= '0;
            hld_q       <= '0;
            dir_q       <= UP;
            prev_q      <= '0;
            wrap_q      <= 1'b0;
        end else begin
            error_q <= 1'b0;
            if (sample_i) begin
                if (single) position_q <= p;
                case (state_q)
                    HUNT: begin
                        if (single) begin
                            state_q <= TRACK;
                            prev_q  <= p;
                            stp_q   <= '0;
                            hld_q   <= '0;
                            wrap_q  <= 1'b0;
                        end
                    end
                    default: begin
                        if (consistent) begin
                            hld_q  <= hold ? hld_d : 8'd0;
                            wrap_q <= blank_ok;
                            dir_q  <= dir_d;
                            if (single) prev_q <= p;
                            if (step_ok && stp_q != LOCK_N_W) stp_q <= stp_q + 8'd1;
                            if (state_q != LOCKED && step_ok && stp_q + 8'd1 == LOCK_N_W) begin
                                state_q   <= LOCKED;
                                locked_q  <= 1'b1;
                                pattern_q <= dir_d;
                            end
                            if (state_q == LOCKED && rev) pattern_q <= BOUNCE;
                        end else begin
                            hld_q     <= '0;
                            wrap_q    <= 1'b0;
                            stp_q     <= '0;
                            pattern_q <= UNKNOWN;
                            locked_q  <= 1'b0;
                            if (state_q == LOCKED) begin
                                error_q <= 1'b1;
                                if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
                            end
                            if (single) begin
                                state_q <= TRACK;
                                prev_q  <= p;
                            end else begin
                                state_q <= HUNT;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign position_o  = position_q;
    assign pattern_o   = pattern_q;
    assign locked_o    = locked_q;
    assign error_o     = error_q;
    assign err_count_o = err_count_q;
endmodule

// File: tb/tb_dance_monitor.sv
// tb/tb_dance_monitor.sv - table-driven scoreboard bench for dance_monitor
module tb_dance_monitor;
    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        sample_i = 1'b0;
    logic [17:0] led_i = '0;
    logic [4:0]  position_o;
    logic [1:0]  pattern_o;
    logic        locked_o;
    logic        error_o;
    logic [7:0]  err_count_o;

    dance_monitor #(.LOCK_N(4), .HOLD_MAX(2)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .sample_i    (sample_i),
        .led_i       (led_i),
        .position_o  (position_o),
        .pattern_o   (pattern_o),
        .locked_o    (locked_o),
        .error_o     (error_o),
        .err_count_o (err_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        smp;
        logic [17:0] led;
        logic [4:0]  pos;
        logic [1:0]  pat;
        logic        lk;
        logic        err;
        logic [7:0]  cnt;
        string       tag;
    } vec_t;

    typedef struct packed {
        logic [4:0] pos;
        logic [1:0] pat;
        logic       lk;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    vec_t  vecs[$];
    exp_t  sb_q[$];
    string tag_q[$];
    int    tests = 0;
    int    fails = 0;

    function automatic logic [17:0] oh(input int p);
        logic [17:0] one;
        one = 18'd1;
        return one << p;
    endfunction

    function automatic void add(input logic rst, input logic smp, input logic [17:0] led,
                                input int pos, input int pat, input logic lk, input logic err,
                                input int cnt, input string tag);
        vec_t v;
        v.rst = rst; v.smp = smp; v.led = led;
        v.pos = 5'(pos); v.pat = 2'(pat); v.lk = lk; v.err = err; v.cnt = 8'(cnt);
        v.tag = tag;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v);
        exp_t e, got;
        reset_i  = v.rst;
        sample_i = v.smp;
        led_i    = v.led;
        e = '{pos: v.pos, pat: v.pat, lk: v.lk, err: v.err, cnt: v.cnt};
        sb_q.push_back(e);
        tag_q.push_back(v.tag);
        @(posedge clk);
        #1;
        e   = sb_q.pop_front();
        got = '{pos: position_o, pat: pattern_o, lk: locked_o, err: error_o, cnt: err_count_o};
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL %s: got pos=%0d pat=%0d lk=%0b err=%0b cnt=%0d, want pos=%0d pat=%0d lk=%0b err=%0b cnt=%0d",
                     tag_q.pop_front(), got.pos, got.pat, got.lk, got.err, got.cnt,
                     e.pos, e.pat, e.lk, e.err, e.cnt);
        end else begin
            void'(tag_q.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        add(1, 0, '0, 0, 0, 0, 0, 0, "reset");
        for (int k = 0; k < 4; k++) add(0, 1, oh(k), k, 0, 0, 0, 0, "up_sweep_track");
        add(0, 1, oh(4), 4, 1, 1, 0, 0, "up_sweep_lock");
        add(0, 0, oh(9), 4, 1, 1, 0, 0, "idle_hold");
        for (int k = 5; k < 18; k++) add(0, 1, oh(k), k, 1, 1, 0, 0, "up_run");
        add(0, 1, '0, 17, 1, 1, 0, 0, "wrap_blank");
        add(0, 1, oh(0), 0, 1, 1, 0, 0, "wrap_zero");
        add(0, 1, oh(1), 1, 1, 1, 0, 0, "after_wrap");
        add(0, 1, oh(1), 1, 1, 1, 0, 0, "hold1");
        add(0, 1, oh(1), 1, 1, 1, 0, 0, "hold2");
        add(0, 1, oh(1), 1, 0, 0, 1, 1, "hold_overflow");
        add(0, 0, '0, 1, 0, 0, 0, 1, "error_one_cycle");
        add(0, 1, oh(13), 13, 0, 0, 0, 1, "track_restart_no_err");
        for (int k = 12; k > 9; k--) add(0, 1, oh(k), k, 0, 0, 0, 1, "down_track");
        add(0, 1, oh(9), 9, 2, 1, 0, 1, "down_lock");
        add(0, 1, 18'h00300, 9, 0, 0, 1, 2, "multi_fault");
        add(0, 0, '0, 9, 0, 0, 0, 2, "fault_pulse_end");
        for (int k = 11; k < 15; k++) add(0, 1, oh(k), k, 0, 0, 0, 2, "relock_track");
        add(0, 1, oh(15), 15, 1, 1, 0, 2, "relock_up");
        add(0, 1, oh(16), 16, 1, 1, 0, 2, "bounce_16");
        add(0, 1, oh(17), 17, 1, 1, 0, 2, "bounce_17");
        add(0, 1, oh(17), 17, 1, 1, 0, 2, "bounce_hold");
        add(0, 1, oh(16), 16, 3, 1, 0, 2, "bounce_reverse");
        add(0, 1, oh(15), 15, 3, 1, 0, 2, "bounce_down");
        add(0, 1, '0, 15, 0, 0, 1, 3, "blank_while_down");
        add(0, 1, oh(2), 2, 0, 0, 0, 3, "dwrap_hunt");
        add(0, 1, oh(1), 1, 0, 0, 0, 3, "dwrap_1");
        add(0, 1, oh(0), 0, 0, 0, 0, 3, "dwrap_0");
        add(0, 1, oh(17), 17, 0, 0, 0, 3, "dwrap_17");
        add(0, 1, oh(16), 16, 2, 1, 0, 3, "dwrap_lock");
        add(0, 1, oh(3), 3, 0, 0, 1, 4, "jump_fault");
        add(0, 1, oh(4), 4, 0, 0, 0, 4, "mid_track");
        add(1, 1, oh(5), 0, 0, 0, 0, 0, "reset_with_sample");
        add(0, 1, '0, 0, 0, 0, 0, 0, "post_reset_blank");
        add(0, 1, 18'h30000, 0, 0, 0, 0, 0, "post_reset_multi");
        add(0, 1, oh(7), 7, 0, 0, 0, 0, "post_reset_single");

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // saturation: repeatedly lock then break with a MULTI frame
        begin
            int c;
            c = 0;
            for (int it = 0; it < 257; it++) begin
                for (int k = 0; k < 4; k++) begin
                    v = '{rst: 0, smp: 1, led: oh(k), pos: 5'(k), pat: 2'd0, lk: 1'b0, err: 1'b0,
                          cnt: 8'(c), tag: "sat_track"};
                    apply(v);
                end
                v = '{rst: 0, smp: 1, led: oh(4), pos: 5'd4, pat: 2'd1, lk: 1'b1, err: 1'b0,
                      cnt: 8'(c), tag: "sat_lock"};
                apply(v);
                c = (c < 255) ? c + 1 : 255;
                v = '{rst: 0, smp: 1, led: 18'h00011, pos: 5'd4, pat: 2'd0, lk: 1'b0, err: 1'b1,
                      cnt: 8'(c), tag: "sat_error"};
                apply(v);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
